// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between a requester and the apb_slave_regfile completer.
// Signal names follow the S_P* naming used on the NoC slave ports.
interface apb_slave_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  S_PSEL;
    logic                  S_PENABLE;
    logic                  S_PWRITE;
    logic [ADDR_W-1:0]     S_PADDR;
    logic [DATA_W-1:0]     S_PDATA;
    logic [DATA_W/8-1:0]   S_PSTRB;
    logic [DATA_W-1:0]     S_PRDATA;
    logic                  S_PREADY;
    logic                  S_PSLVERR;

    modport master (
        output S_PSEL, S_PENABLE, S_PWRITE, S_PADDR, S_PDATA, S_PSTRB,
        input  S_PRDATA, S_PREADY, S_PSLVERR
    );

    modport slave (
        input  S_PSEL, S_PENABLE, S_PWRITE, S_PADDR, S_PDATA, S_PSTRB,
        output S_PRDATA, S_PREADY, S_PSLVERR
    );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB completer with a bank of RW registers (byte-strobed writes, per-register
// write pulses) followed by RO status words, fixed wait states and a registered
// response. Optional macro APB_SLV_ERR_EN drives S_PSLVERR on bad accesses;
// without it, bad accesses still never commit and reads of them return 0.
module apb_slave_regfile #(
    parameter int                 DATA_W      = 32,
    parameter int                 ADDR_W      = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR   = '0,
    parameter int                 NUM_RW      = 12,
    parameter int                 NUM_RO      = 4,
    parameter int                 WAIT_CYCLES = 0,
    parameter logic [DATA_W-1:0]  RESET_VAL   = '0
) (
    input  logic                                      ACLK,
    input  logic                                      ASW_RESET,
    apb_slave_regfile_if.slave                        s_apb,
    output logic [NUM_RW*DATA_W-1:0]                  reg_q,
    output logic [NUM_RW-1:0]                         wr_pulse,
    input  logic [((NUM_RO > 0) ? NUM_RO : 1)*DATA_W-1:0] ro_in
);
    localparam int STRB_W = DATA_W / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int TOTAL  = NUM_RW + NUM_RO;
    localparam int IDX_W  = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int RO_N   = (NUM_RO > 0) ? NUM_RO : 1;
    localparam logic [ADDR_W-1:0] LSB_MASK = ADDR_W'((1 << LSB) - 1);
    localparam logic [IDX_W:0]    NUM_RW_X = (IDX_W + 1)'(NUM_RW);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_READY} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                write_q, write_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   strb_q, strb_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                slverr_q, slverr_d;
    logic                commit;

    logic [ADDR_W-1:0]   off, idx_full;
    logic                live_valid, live_err;
    logic [IDX_W-1:0]    live_idx;
    logic [IDX_W-1:0]    cur_idx;
    logic                cur_write, cur_err;
    logic [DATA_W-1:0]   rd_word;

    logic [DATA_W-1:0]   regs_w   [NUM_RW];
    logic [DATA_W-1:0]   ro_words [RO_N];

    for (genvar gi = 0; gi < RO_N; gi++) begin : g_ro
        assign ro_words[gi] = ro_in[gi*DATA_W +: DATA_W];
    end

    // Address decode of the live bus (used while a setup phase is sampled).
    always_comb begin
        off        = s_apb.S_PADDR - BASE_ADDR;
        idx_full   = off >> LSB;
        live_idx   = idx_full[IDX_W-1:0];
        live_valid = (s_apb.S_PADDR >= BASE_ADDR) &&
                     ((off & LSB_MASK) == '0) &&
                     (idx_full < ADDR_W'(TOTAL));
        live_err   = !live_valid || (s_apb.S_PWRITE && ({1'b0, live_idx} >= NUM_RW_X));
    end

    // Transfer attributes seen on entry to READY: live when coming straight
    // from the setup cycle, captured otherwise.
    always_comb begin
        cur_idx   = idx_q;
        cur_write = write_q;
        cur_err   = err_q;
        if (state_q == ST_IDLE) begin
            cur_idx   = live_idx;
            cur_write = s_apb.S_PWRITE;
            cur_err   = live_err;
        end
    end

    // Read mux over RW registers then RO words.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            if ({1'b0, cur_idx} == (IDX_W + 1)'(i)) rd_word = regs_w[i];
        end
        for (int i = 0; i < NUM_RO; i++) begin
            if ({1'b0, cur_idx} == (IDX_W + 1)'(NUM_RW + i)) rd_word = ro_words[i];
        end
    end

    // Next-state, capture and response logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        write_d  = write_q;
        err_d    = err_q;
        wdata_d  = wdata_q;
        strb_d   = strb_q;
        rdata_d  = rdata_q;
        slverr_d = slverr_q;
        commit   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s_apb.S_PSEL && !s_apb.S_PENABLE) begin
                    idx_d   = live_idx;
                    write_d = s_apb.S_PWRITE;
                    err_d   = live_err;
                    wdata_d = s_apb.S_PDATA;
                    strb_d  = s_apb.S_PSTRB;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? ST_READY : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!(s_apb.S_PSEL && s_apb.S_PENABLE)) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd1) begin
                    state_d = ST_READY;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_READY: begin
                state_d = ST_IDLE;
                commit  = s_apb.S_PSEL && s_apb.S_PENABLE && s_apb.S_PWRITE &&
                          write_q && !err_q;
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d == ST_READY && state_q != ST_READY) begin
            rdata_d = (cur_write || cur_err) ? '0 : rd_word;
`ifdef APB_SLV_ERR_EN
            slverr_d = cur_err;
`else
            slverr_d = 1'b0;
`endif
        end
    end

    // FSM state, captured transfer and registered response.
    always_ff @(posedge ACLK) begin
        if (ASW_RESET) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
            rdata_q  <= '0;
            slverr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            write_q  <= write_d;
            err_q    <= err_d;
            wdata_q  <= wdata_d;
            strb_q   <= strb_d;
            rdata_q  <= rdata_d;
            slverr_q <= slverr_d;
        end
    end

    for (genvar gi = 0; gi < NUM_RW; gi++) begin : g_rw
        logic [DATA_W-1:0] word_q;
        logic              pulse_q;
        logic              hit;

        assign hit = commit && ({1'b0, idx_q} == (IDX_W + 1)'(gi));

        // Byte-strobed register update and its one-cycle write pulse.
        always_ff @(posedge ACLK) begin
            if (ASW_RESET) begin
                word_q  <= RESET_VAL;
                pulse_q <= 1'b0;
            end else begin
                pulse_q <= hit;
                if (hit) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (strb_q[b]) word_q[b*8 +: 8] <= wdata_q[b*8 +: 8];
                    end
                end
            end
        end

        assign regs_w[gi]                    = word_q;
        assign reg_q[gi*DATA_W +: DATA_W]    = word_q;
        assign wr_pulse[gi]                  = pulse_q;
    end

    assign s_apb.S_PREADY  = (state_q == ST_READY);
    assign s_apb.S_PRDATA  = rdata_q;
    assign s_apb.S_PSLVERR = slverr_q;
endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: two instances (0 and 3 wait states) driven by
// directed APB transfers, checked cycle by cycle against a transfer-level model.
module tb_apb_slave_regfile;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int NRW = 12;
    localparam int NRO = 4;
    localparam int WC0 = 0;
    localparam int WC1 = 3;
    localparam logic [31:0] RV = 32'h5A5A_0F0F;
`ifdef APB_SLV_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic              psel [2];
    logic              penable [2];
    logic              pwrite [2];
    logic [31:0]       paddr [2];
    logic [31:0]       pdata [2];
    logic [3:0]        pstrb [2];
    logic [31:0]       prdata [2];
    logic              pready [2];
    logic              pslverr [2];
    logic [NRW*DW-1:0] regq [2];
    logic [NRW-1:0]    wrp [2];
    logic [NRO*DW-1:0] roin [2];

    apb_slave_regfile_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
    apb_slave_regfile_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

    assign bus0.S_PSEL    = psel[0];
    assign bus0.S_PENABLE = penable[0];
    assign bus0.S_PWRITE  = pwrite[0];
    assign bus0.S_PADDR   = paddr[0];
    assign bus0.S_PDATA   = pdata[0];
    assign bus0.S_PSTRB   = pstrb[0];
    assign prdata[0]      = bus0.S_PRDATA;
    assign pready[0]      = bus0.S_PREADY;
    assign pslverr[0]     = bus0.S_PSLVERR;

    assign bus1.S_PSEL    = psel[1];
    assign bus1.S_PENABLE = penable[1];
    assign bus1.S_PWRITE  = pwrite[1];
    assign bus1.S_PADDR   = paddr[1];
    assign bus1.S_PDATA   = pdata[1];
    assign bus1.S_PSTRB   = pstrb[1];
    assign prdata[1]      = bus1.S_PRDATA;
    assign pready[1]      = bus1.S_PREADY;
    assign pslverr[1]     = bus1.S_PSLVERR;

    apb_slave_regfile #(
        .DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(32'h0), .NUM_RW(NRW), .NUM_RO(NRO),
        .WAIT_CYCLES(WC0), .RESET_VAL(RV)
    ) u_dut0 (
        .ACLK(clk), .ASW_RESET(rst), .s_apb(bus0),
        .reg_q(regq[0]), .wr_pulse(wrp[0]), .ro_in(roin[0])
    );

    apb_slave_regfile #(
        .DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(32'h0), .NUM_RW(NRW), .NUM_RO(NRO),
        .WAIT_CYCLES(WC1), .RESET_VAL(RV)
    ) u_dut1 (
        .ACLK(clk), .ASW_RESET(rst), .s_apb(bus1),
        .reg_q(regq[1]), .wr_pulse(wrp[1]), .ro_in(roin[1])
    );

    function automatic int wc(input int k);
        return (k == 0) ? WC0 : WC1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- transfer-level model ----------------
    int           cyc = 0;
    logic [31:0]  m_regs [2][NRW];
    bit           m_active [2];
    int           m_t0 [2];
    bit           m_wr [2];
    bit           m_err [2];
    int           m_idx [2];
    logic [31:0]  m_data [2];
    logic [3:0]   m_strb [2];
    bit           exp_ready [2];
    logic [31:0]  exp_rdata [2];
    bit           exp_err [2];
    logic [NRW-1:0] exp_pulse [2];

    // A transfer set up in cycle t0 is ready in cycle t0+1+W; its write lands
    // on the edge closing that cycle, unless PSEL/PENABLE dropped before it.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_active[k]  = 1'b0;
                exp_ready[k] = 1'b0;
                exp_rdata[k] = '0;
                exp_err[k]   = 1'b0;
                exp_pulse[k] = '0;
                for (int i = 0; i < NRW; i++) m_regs[k][i] = RV;
            end else begin
                exp_pulse[k] = '0;
                if (m_active[k]) begin
                    if (!(psel[k] && penable[k])) begin
                        m_active[k] = 1'b0;
                    end else if (cyc == m_t0[k] + 1 + wc(k)) begin
                        if (m_wr[k] && !m_err[k]) begin
                            for (int b = 0; b < 4; b++)
                                if (m_strb[k][b]) m_regs[k][m_idx[k]][8*b +: 8] = m_data[k][8*b +: 8];
                            exp_pulse[k][m_idx[k]] = 1'b1;
                        end
                        m_active[k] = 1'b0;
                    end
                end else if (psel[k] && !penable[k]) begin
                    m_t0[k]     = cyc;
                    m_wr[k]     = pwrite[k];
                    m_data[k]   = pdata[k];
                    m_strb[k]   = pstrb[k];
                    m_idx[k]    = int'(paddr[k] / 4);
                    m_err[k]    = (paddr[k] % 4 != 0) || (paddr[k] / 4 >= NRW + NRO) ||
                                  (pwrite[k] && (paddr[k] / 4 >= NRW));
                    m_active[k] = 1'b1;
                end
                exp_ready[k] = m_active[k] && (cyc + 1 == m_t0[k] + 1 + wc(k));
                if (exp_ready[k]) begin
                    if (m_wr[k] || m_err[k])  exp_rdata[k] = '0;
                    else if (m_idx[k] < NRW)  exp_rdata[k] = m_regs[k][m_idx[k]];
                    else                      exp_rdata[k] = roin[k][(m_idx[k]-NRW)*32 +: 32];
                    exp_err[k] = ERR_EN && m_err[k];
                end
            end
        end
        cyc++;
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (!rst && cyc > 0) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("pready[%0d] cyc %0d", k, cyc), 64'(pready[k]), 64'(exp_ready[k]));
                if (exp_ready[k]) begin
                    chk($sformatf("prdata[%0d] cyc %0d", k, cyc), 64'(prdata[k]), 64'(exp_rdata[k]));
                    chk($sformatf("pslverr[%0d] cyc %0d", k, cyc), 64'(pslverr[k]), 64'(exp_err[k]));
                end
                chk($sformatf("wr_pulse[%0d] cyc %0d", k, cyc), 64'(wrp[k]), 64'(exp_pulse[k]));
                for (int i = 0; i < NRW; i++)
                    chk($sformatf("reg_q[%0d][%0d] cyc %0d", k, i, cyc),
                        64'(regq[k][i*32 +: 32]), 64'(m_regs[k][i]));
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic setup(input int k, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr;
        paddr[k] = a; pdata[k] = d; pstrb[k] = s;
    endtask

    task automatic access(input int k, output logic [31:0] rd, output logic er);
        int n;
        @(posedge clk); #1 penable[k] = 1'b1;
        @(negedge clk);
        n = 0;
        while (!pready[k] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("latency[%0d]", k), 64'(n), 64'(wc(k)));
        rd = prdata[k];
        er = pslverr[k];
        $display("[TB] dut%0d %s addr=%h wdata=%h strb=%h -> rdata=%h err=%0d wait=%0d",
                 k, pwrite[k] ? "WR" : "RD", paddr[k], pdata[k], pstrb[k], rd, er, n);
    endtask

    task automatic xfer(input int k, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output logic er);
        @(posedge clk); #1 setup(k, wr, a, d, s);
        access(k, rd, er);
    endtask

    task automatic idle(input int k);
        @(posedge clk); #1 psel[k] = 1'b0; penable[k] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        for (int k = 0; k < 2; k++) begin
            psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0;
            paddr[k] = '0; pdata[k] = '0; pstrb[k] = '0;
        end
        roin[0] = {32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000};
        roin[1] = {32'hD00D0003, 32'hD00D0002, 32'hD00D0001, 32'hD00D0000};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset pready", 64'(pready[0]), 64'(0));
        chk("reset prdata", 64'(prdata[0]), 64'(0));
        chk("reset pslverr", 64'(pslverr[0]), 64'(0));
        chk("reset reg0", 64'(regq[0][31:0]), 64'h5A5A0F0F);
        chk("reset pulse", 64'(wrp[0]), 64'(0));

        // ---- zero wait states ----
        xfer(0, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, rd, er);
        chk("write 0x08 err", 64'(er), 64'(0));
        idle(0);
        @(negedge clk);
        chk("pulse after write 0x08", 64'(wrp[0]), 64'h004);
        chk("reg2 after write", 64'(regq[0][95:64]), 64'hDEADBEEF);
        @(negedge clk);
        chk("pulse one cycle", 64'(wrp[0]), 64'h000);
        xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, rd, er);
        chk("read 0x08", 64'(rd), 64'hDEADBEEF);
        idle(0);

        xfer(0, 1'b1, 32'h04, 32'h11223344, 4'hF, rd, er);
        xfer(0, 1'b1, 32'h04, 32'hAABBCCDD, 4'h5, rd, er);
        xfer(0, 1'b0, 32'h04, 32'h0, 4'hF, rd, er);
        chk("partial strobe read", 64'(rd), 64'h11BB33DD);
        idle(0);

        xfer(0, 1'b1, 32'h0C, 32'hFFFFFFFF, 4'h0, rd, er);
        idle(0);
        @(negedge clk);
        chk("pulse strb0", 64'(wrp[0]), 64'h008);
        chk("reg3 strb0 unchanged", 64'(regq[0][127:96]), 64'h5A5A0F0F);

        xfer(0, 1'b0, 32'h34, 32'h0, 4'h0, rd, er);
        chk("ro read 0x34", 64'(rd), 64'hC0DE0001);
        chk("ro read err", 64'(er), 64'(0));

        xfer(0, 1'b1, 32'h30, 32'h12345678, 4'hF, rd, er);
        chk("ro write err", 64'(er), 64'(ERR_EN));
        idle(0);
        @(negedge clk);
        chk("ro write no pulse", 64'(wrp[0]), 64'h000);

        xfer(0, 1'b1, 32'h06, 32'h00000099, 4'hF, rd, er);
        chk("misaligned write err", 64'(er), 64'(ERR_EN));
        idle(0);
        @(negedge clk);
        chk("misaligned no pulse", 64'(wrp[0]), 64'h000);
        chk("reg1 unchanged", 64'(regq[0][63:32]), 64'h11BB33DD);

        xfer(0, 1'b0, 32'h06, 32'h0, 4'h0, rd, er);
        chk("misaligned read err", 64'(er), 64'(ERR_EN));
        chk("misaligned read data", 64'(rd), 64'(0));
        xfer(0, 1'b0, 32'h40, 32'h0, 4'h0, rd, er);
        chk("out-of-range err", 64'(er), 64'(ERR_EN));
        chk("out-of-range data", 64'(rd), 64'(0));

        xfer(0, 1'b1, 32'h10, 32'hCAFEF00D, 4'hF, rd, er);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er);
        chk("back-to-back read", 64'(rd), 64'hCAFEF00D);
        idle(0);

        // ---- three wait states ----
        xfer(1, 1'b0, 32'h00, 32'h0, 4'h0, rd, er);
        chk("w3 reset read", 64'(rd), 64'h5A5A0F0F);
        xfer(1, 1'b1, 32'h00, 32'h12345678, 4'hF, rd, er);
        xfer(1, 1'b0, 32'h00, 32'h0, 4'h0, rd, er);
        chk("w3 readback", 64'(rd), 64'h12345678);
        idle(1);

        @(posedge clk); #1 setup(1, 1'b1, 32'h00, 32'hFFFFFFFF, 4'hF);
        @(posedge clk); #1 penable[1] = 1'b1;
        @(posedge clk); #1 psel[1] = 1'b0; penable[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("abort no pready %0d", i), 64'(pready[1]), 64'(0));
            chk($sformatf("abort no pulse %0d", i), 64'(wrp[1]), 64'(0));
        end
        xfer(1, 1'b0, 32'h00, 32'h0, 4'h0, rd, er);
        chk("abort reg unchanged", 64'(rd), 64'h12345678);
        idle(1);

        @(posedge clk); #1 setup(1, 1'b0, 32'h04, 32'h0, 4'h0);
        @(posedge clk); #1 penable[1] = 1'b1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        setup(1, 1'b0, 32'h00, 32'h0, 4'h0);
        @(negedge clk);
        chk("post-reset pready", 64'(pready[1]), 64'(0));
        chk("post-reset prdata", 64'(prdata[1]), 64'(0));
        chk("post-reset reg0", 64'(regq[1][31:0]), 64'h5A5A0F0F);
        chk("post-reset dut0 reg2", 64'(regq[0][95:64]), 64'h5A5A0F0F);
        access(1, rd, er);
        chk("post-reset read", 64'(rd), 64'h5A5A0F0F);
        idle(1);

        xfer(1, 1'b1, 32'h3C, 32'h55AA55AA, 4'hF, rd, er);
        chk("w3 ro write err", 64'(er), 64'(ERR_EN));
        idle(1);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/apb_slave_regfile.md
# apb_slave_regfile

Parametrised APB completer with a built-in register bank, programmable wait states, byte strobes and error response. Sits behind any NoC APB slave port (S0..Sn) in place of a bare signal bundle. Provides a self-contained, protocol-checked register endpoint for bring-up and for the UVM environment's APB slave agents. Exports RW register contents and per-register write pulses to local logic, and imports RO status words.

## Interface
- DATA_W, 32: APB data width; legal values 8, 16, 32, 64.
- ADDR_W, 32: PADDR width.
- BASE_ADDR, 0: byte address of register 0; must be DATA_W/8-aligned.
- NUM_RW, 12: number of read/write registers, indices 0..NUM_RW-1; must be at least 1.
- NUM_RO, 4: number of read-only registers, indices NUM_RW..NUM_RW+NUM_RO-1; may be 0.
- WAIT_CYCLES, 0: wait states inserted per transfer; legal range 0..15.
- RESET_VAL, 0: reset value of every RW register.

Ports (name, direction, width, meaning):
- ACLK  in  1  clock; all logic on rising edge.
- ASW_RESET  in  1  reset, synchronous, active-high.
- S_PSEL  in  1  slave select.
- S_PENABLE  in  1  access phase.
- S_PWRITE  in  1  1 = write.
- S_PADDR  in  ADDR_W  byte address.
- S_PDATA  in  DATA_W  write data.
- S_PSTRB  in  DATA_W/8  write byte strobes.
- S_PRDATA  out  DATA_W  read data.
- S_PREADY  out  1  transfer completes this cycle.
- S_PSLVERR  out  1  error; valid only while S_PREADY=1.
- reg_q  out  NUM_RW*DATA_W  flattened RW registers; register i occupies bits [i*DATA_W +: DATA_W].
- wr_pulse  out  NUM_RW  one-cycle pulse in the cycle after register i is written.
- ro_in  in  max(NUM_RO,1)*DATA_W  RO register values, packed the same way as reg_q.

## Operation
- Decode:
  - off = S_PADDR - BASE_ADDR.
  - idx = off >> log2(DATA_W/8).
  - Address is valid when: S_PADDR >= BASE_ADDR, the low log2(DATA_W/8) bits of off are 0, and idx < NUM_RW+NUM_RO.
  - Address and data are captured at the end of the setup cycle.
- FSM states IDLE, WAIT, READY:
  - IDLE: on S_PSEL=1 and S_PENABLE=0, capture the transfer and load cnt=WAIT_CYCLES. Go to READY if WAIT_CYCLES=0, otherwise WAIT.
  - WAIT: cnt decrements each cycle. At cnt=1 go to READY.
  - READY: S_PREADY=1, and S_PRDATA/S_PSLVERR hold the registered response. Go to IDLE on the next edge.
- Write commit: occurs on the READY-cycle edge when S_PSEL=1, S_PENABLE=1, S_PWRITE=1 and no error.
  - Byte lane b of register idx is updated only when S_PSTRB[b]=1.
  - wr_pulse[idx] is high for exactly the following cycle, including when S_PSTRB=0.
- Reads:
  - S_PRDATA is registered on entry to READY: reg_q[idx] or ro_in[idx-NUM_RW].
  - S_PRDATA is 0 for writes and for errors. S_PSTRB is ignored on reads.
- Errors: invalid address, or any write to an RO index.
  - The transfer completes with the normal wait count.
  - No register changes and no wr_pulse.
- Abort: if S_PSEL or S_PENABLE is low while in WAIT or READY, return to IDLE.
  - No commit, no pulse, and S_PREADY deasserts next cycle.
- Back-to-back transfers: a setup phase seen in the cycle after READY starts a new transfer. There are no idle bubbles beyond APB's own setup cycle.

## Timing
- Cycle numbering: setup cycle t0, first access cycle t1. S_PREADY=1 exactly in cycle t1+WAIT_CYCLES.
- Transfer length is 2+WAIT_CYCLES cycles.
- The written value is visible on reg_q in cycle t2+WAIT_CYCLES, coincident with wr_pulse.
- All outputs are registered. None depend combinationally on inputs.
- Reset: on any edge with ASW_RESET=1 the block goes to IDLE.
  - S_PREADY=0, S_PSLVERR=0, S_PRDATA=0, wr_pulse=0, and all RW registers take RESET_VAL.
  - Reset mid-transfer drops the transfer without commit.

## Configuration
- APB_SLV_ERR_EN defined: S_PSLVERR is driven as described under Operation.
- APB_SLV_ERR_EN undefined:
  - S_PSLVERR is tied 0.
  - Error transfers complete "OK" but are still non-committing: writes are silently dropped and reads return 0.
  - The decode logic is unchanged.

## Test plan
- DATA_W=32, WAIT_CYCLES=0: write 0xDEADBEEF to 0x08 with PSTRB=0xF, then read 0x08. Required response: PREADY in t1 of each transfer, PRDATA=0xDEADBEEF, wr_pulse[2] high for one cycle.
- Partial strobe: reg 1 = 0x11223344, write 0xAABBCCDD with PSTRB=0x5. Reading back returns 0x11BB33DD.
- WAIT_CYCLES=3: a read completes with PREADY in cycle t4 and is low in t1..t3. Abort by dropping PSEL at t2: no PREADY, reg unchanged.
- With APB_SLV_ERR_EN defined, each of these gives PSLVERR=1, no wr_pulse and unchanged reg_q:
  - write to an RO index;
  - misaligned address 0x06;
  - address (NUM_RW+NUM_RO)*4.
  - Without the macro, PSLVERR stays 0 for the same cases.
- Assert ASW_RESET during WAIT: the next cycle shows PREADY=0, PRDATA=0, all reg_q=RESET_VAL, and the FSM accepts a new setup immediately after.
- Back-to-back write then read to the same register, PSEL held high: the read returns the newly written data.
